// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch (IFU) and
// load/store (LSU) requesters, one transaction at a time.
//
// The request/grant/response FSM registers the winning request, presents a
// word-aligned payload to memory, and returns the response as a one-cycle
// rvalid pulse to the owner. Stores are lane-steered (replicated data plus a
// byte mask). Loads are lane-selected and sign/zero-extended using the RISC-V
// funct3 memop encoding.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog. It forces a
// response of 32'hDEADBEEF after TIMEOUT_CYCLES in REQ/WAIT and sets a sticky
// err flag. Without the macro the FSM waits indefinitely and err is 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ifu_valid/addr/ready     fetch request (always a word access)
//   ifu_rvalid/rdata         fetch response pulse and raw word
//   lsu_valid/addr/wen/      load/store request; memop is funct3,
//   lsu_memop/wdata/ready    wdata is right-aligned
//   lsu_rvalid/rdata         completion pulse (stores too) and extended data
//   mem_req/addr/wen/        memory request, held until mem_gnt
//   mem_wdata/wmask
//   mem_gnt/rvalid/rdata     memory grant and response
//   err                      sticky timeout flag
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_valid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_memop,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    localparam logic [2:0]  OpW      = 3'b010;
    localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

    // Size is decoded from memop[1:0] (00 byte, 01 half, else word), so the
    // undefined encodings 011/110/111 fall through to word naturally.
    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
        case (op[1:0])
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = off[1] ? 4'b1100 : 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // memop[2] marks the unsigned variants (BU/HU).
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] op,
                                                input logic [1:0] off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        case (op[1:0])
            2'b00:   load_extend = {{24{b[7] & ~op[2]}}, b};
            2'b01:   load_extend = {{16{h[15] & ~op[2]}}, h};
            default: load_extend = rdata;
        endcase
    endfunction

    state_e      state_q;
    logic        owner_lsu_q;
    logic        last_lsu_q;
    logic [2:0]  memop_q;
    logic [1:0]  offset_q;

    logic        idle;
    logic        lsu_accept;
    logic        ifu_accept;
    logic        accept;
    logic        busy;
    logic        rsp_hit;
    logic        timeout_hit;
    logic        complete;
    logic [31:0] acc_addr;
    logic        acc_wen;
    logic [2:0]  acc_op;
    logic [31:0] ifu_resp;
    logic [31:0] lsu_resp;

    // Gating with rst keeps both readies low while reset is held.
    assign idle       = rst && (state_q == StIdle);
    assign lsu_ready  = idle && !(last_lsu_q && ifu_valid);
    assign lsu_accept = lsu_valid && lsu_ready;
    // lsu_accept doubles as "LSU requesting and allowed to win".
    assign ifu_ready  = idle && !lsu_accept;
    assign ifu_accept = ifu_valid && ifu_ready;
    assign accept     = lsu_accept || ifu_accept;

    assign busy     = (state_q == StReq) || (state_q == StWait);
    // mem_rvalid only counts in WAIT; in IDLE/REQ it is ignored.
    assign rsp_hit  = (state_q == StWait) && mem_rvalid;
    assign complete = rsp_hit || timeout_hit;

    always_comb begin
        acc_addr = lsu_accept ? lsu_addr : ifu_addr;
        acc_wen  = lsu_accept && lsu_wen;
        acc_op   = lsu_accept ? lsu_memop : OpW;
    end

    always_comb begin
        ifu_resp = mem_rdata;
        lsu_resp = mem_wen ? 32'h0 : load_extend(mem_rdata, memop_q, offset_q);
        if (!rsp_hit) begin
            ifu_resp = TimeoutData;
            lsu_resp = TimeoutData;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] count_q;
    logic            err_q;

    // Fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign timeout_hit = busy && ((32'(count_q) + 32'd1) == TIMEOUT_CYCLES);
    assign err         = err_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign err                = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            memop_q     <= 3'b000;
            offset_q    <= 2'b00;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wen     <= 1'b0;
            mem_wdata   <= 32'h0;
            mem_wmask   <= 4'b0000;
            ifu_rvalid  <= 1'b0;
            ifu_rdata   <= 32'h0;
            lsu_rvalid  <= 1'b0;
            lsu_rdata   <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            count_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StReq;
                        owner_lsu_q <= lsu_accept;
                        last_lsu_q  <= lsu_accept;
                        memop_q     <= acc_op;
                        offset_q    <= acc_addr[1:0];
                        mem_req     <= 1'b1;
                        mem_addr    <= {acc_addr[31:2], 2'b00};
                        mem_wen     <= acc_wen;
                        mem_wdata   <= acc_wen ? store_data(acc_op, lsu_wdata) : 32'h0;
                        mem_wmask   <= acc_wen ? store_mask(acc_op, acc_addr[1:0]) : 4'b0000;
                    end
                end
                StReq: begin
                    if (complete) begin
                        state_q <= StResp;
                        mem_req <= 1'b0;
                    end else if (mem_gnt) begin
                        state_q <= StWait;
                        mem_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (complete) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (complete) begin
                if (owner_lsu_q) begin
                    lsu_rvalid <= 1'b1;
                    lsu_rdata  <= lsu_resp;
                end else begin
                    ifu_rvalid <= 1'b1;
                    ifu_rdata  <= ifu_resp;
                end
            end

`ifdef MEM_ARB_TIMEOUT_EN
            if (accept) begin
                count_q <= '0;
            end else if (busy) begin
                count_q <= count_q + CntW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned TimeoutCycles = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_valid = 1'b0;
    logic [31:0] ifu_addr = 32'h0;
    logic        ifu_ready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_valid = 1'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic        lsu_wen = 1'b0;
    logic [2:0]  lsu_memop = 3'b010;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_ready;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Memory responder state
    bit          mem_auto = 1'b1;
    int          gnt_delay = 0;
    bit          rsp_hold = 1'b0;
    bit          spurious = 1'b0;
    bit          gnt_fired = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wmask;
    logic        cap_wen;

    mem_arbiter #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_valid  (ifu_valid),
        .ifu_addr   (ifu_addr),
        .ifu_ready  (ifu_ready),
        .ifu_rvalid (ifu_rvalid),
        .ifu_rdata  (ifu_rdata),
        .lsu_valid  (lsu_valid),
        .lsu_addr   (lsu_addr),
        .lsu_wen    (lsu_wen),
        .lsu_memop  (lsu_memop),
        .lsu_wdata  (lsu_wdata),
        .lsu_ready  (lsu_ready),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and run the memory model: grant in the
    // same cycle mem_req is seen (after gnt_delay), read data one cycle later.
    task automatic step();
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (gnt_fired && !rsp_hold) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_data;
        end
        gnt_fired = 1'b0;
        mem_gnt   = 1'b0;
        if (mem_req && mem_auto) begin
            if (gnt_delay > 0) begin
                gnt_delay--;
                if (spurious) mem_rvalid = 1'b1;
            end else begin
                mem_gnt   = 1'b1;
                gnt_fired = 1'b1;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wmask = mem_wmask;
                cap_wen   = mem_wen;
            end
        end
    endtask

    // Issue one request from the IDLE falling edge and wait (bounded) for the
    // owner's rvalid; lat is the number of falling edges to it, -1 on expiry.
    task automatic do_txn(input bit lsu, input logic [31:0] addr, input bit wen,
                          input logic [2:0] op, input logic [31:0] wdata,
                          input logic [31:0] rdata_mem, output int lat,
                          output logic [31:0] rd, output bit wrong_rv);
        rsp_data  = rdata_mem;
        cap_addr  = 32'hFFFF_FFFF;
        cap_wdata = 32'hFFFF_FFFF;
        cap_wmask = 4'hA;
        cap_wen   = 1'bx;
        if (lsu) begin
            lsu_valid = 1'b1;
            lsu_addr  = addr;
            lsu_wen   = wen;
            lsu_memop = op;
            lsu_wdata = wdata;
        end else begin
            ifu_valid = 1'b1;
            ifu_addr  = addr;
        end
        lat      = -1;
        rd       = 32'h0;
        wrong_rv = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 1) begin
                // Inputs are don't-care once accepted; scramble them.
                ifu_valid = 1'b0;
                lsu_valid = 1'b0;
                ifu_addr  = 32'hFFFF_FFFF;
                lsu_addr  = 32'hFFFF_FFFF;
                lsu_wdata = 32'hFFFF_FFFF;
                lsu_memop = ~op;
                lsu_wen   = ~wen;
            end
            if ((lsu ? ifu_rvalid : lsu_rvalid) === 1'b1) wrong_rv = 1'b1;
            if ((lsu ? lsu_rvalid : ifu_rvalid) === 1'b1) begin
                lat = k;
                rd  = lsu ? lsu_rdata : ifu_rdata;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        ifu_valid = 1'b1;
        lsu_valid = 1'b1;
        step();
        step();
        vectors++;
        if (ifu_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ifu_ready: got %b want 0", ifu_ready);
        end
        vectors++;
        if (lsu_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_lsu_ready: got %b want 0", lsu_ready);
        end
        vectors++;
        if ({mem_req, mem_wen, mem_wmask, mem_addr, mem_wdata} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_mem_outputs: got req=%b addr=%h wdata=%h mask=%b want all 0",
                     mem_req, mem_addr, mem_wdata, mem_wmask);
        end
        vectors++;
        if ({ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, err} !== 67'h0) begin
            miscompares++;
            $display("FAIL reset_resp_outputs: got rv=%b%b err=%b want 0", ifu_rvalid,
                     lsu_rvalid, err);
        end
        ifu_valid = 1'b0;
        lsu_valid = 1'b0;
        rst       = 1'b1;
        step();
        vectors++;
        if ({ifu_ready, lsu_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b%b want 11", ifu_ready, lsu_ready);
        end
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] rd; bit wrong;
        do_txn(1'b0, 32'h8000_0000, 1'b0, 3'b010, 32'h0, 32'h0010_0073, lat, rd, wrong);
        vectors++;
        if (lat !== 3) begin
            miscompares++; $display("FAIL fetch_latency: got %0d want 3", lat);
        end
        vectors++;
        if (rd !== 32'h0010_0073) begin
            miscompares++; $display("FAIL fetch_rdata: got %h want 00100073", rd);
        end
        vectors++;
        if ({cap_addr, cap_wen, cap_wmask} !== {32'h8000_0000, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL fetch_payload: got addr=%h wen=%b mask=%b want 80000000 0 0000",
                     cap_addr, cap_wen, cap_wmask);
        end
        vectors++;
        if (wrong !== 1'b0) begin
            miscompares++; $display("FAIL fetch_lsu_rvalid: got 1 want 0");
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] wd;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_mask;
    } st_vec_t;

    task automatic test_store();
        int lat; logic [31:0] rd; bit wrong;
        st_vec_t sv [6];
        sv = '{
            '{32'h104, 3'b000, 32'h0000_00A5, 32'h104, 32'hA5A5_A5A5, 4'b0001},
            '{32'h106, 3'b001, 32'h0000_1234, 32'h104, 32'h1234_1234, 4'b1100},
            '{32'h107, 3'b000, 32'h1234_565A, 32'h104, 32'h5A5A_5A5A, 4'b1000},
            '{32'h10B, 3'b010, 32'hCAFE_F00D, 32'h108, 32'hCAFE_F00D, 4'b1111},
            '{32'h113, 3'b001, 32'hFFFF_8001, 32'h110, 32'h8001_8001, 4'b1100},
            '{32'h115, 3'b011, 32'h0102_0304, 32'h114, 32'h0102_0304, 4'b1111}
        };
        foreach (sv[i]) begin
            do_txn(1'b1, sv[i].addr, 1'b1, sv[i].op, sv[i].wd, 32'h5555_5555, lat, rd, wrong);
            vectors++;
            if ({cap_addr, cap_wdata, cap_wmask, cap_wen} !==
                {sv[i].exp_addr, sv[i].exp_wd, sv[i].exp_mask, 1'b1}) begin
                miscompares++;
                $display("FAIL store_%0d_payload: got addr=%h wdata=%h mask=%b wen=%b want %h %h %b 1",
                         i, cap_addr, cap_wdata, cap_wmask, cap_wen, sv[i].exp_addr,
                         sv[i].exp_wd, sv[i].exp_mask);
            end
            vectors++;
            if ({lat, rd, wrong} !== {32'd3, 32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL store_%0d_resp: got lat=%0d rdata=%h wrong_rv=%b want 3 0 0",
                         i, lat, rd, wrong);
            end
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] mrd;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_load();
        int lat; logic [31:0] rd; bit wrong;
        ld_vec_t lv [9];
        lv = '{
            '{32'h203, 3'b000, 32'h80FF_FFFF, 32'hFFFF_FF80},
            '{32'h203, 3'b100, 32'h80FF_FFFF, 32'h0000_0080},
            '{32'h202, 3'b101, 32'h80FF_FFFF, 32'h0000_80FF},
            '{32'h202, 3'b001, 32'h80FF_FFFF, 32'hFFFF_80FF},
            '{32'h201, 3'b000, 32'h1234_5678, 32'h0000_0056},
            '{32'h200, 3'b001, 32'h1234_F678, 32'hFFFF_F678},
            '{32'h203, 3'b001, 32'h80FF_FFFF, 32'hFFFF_80FF},
            '{32'h206, 3'b010, 32'hDEAD_0001, 32'hDEAD_0001},
            '{32'h200, 3'b111, 32'h8765_4321, 32'h8765_4321}
        };
        foreach (lv[i]) begin
            do_txn(1'b1, lv[i].addr, 1'b0, lv[i].op, 32'hFFFF_FFFF, lv[i].mrd, lat, rd, wrong);
            vectors++;
            if (rd !== lv[i].exp) begin
                miscompares++;
                $display("FAIL load_%0d_rdata: got %h want %h", i, rd, lv[i].exp);
            end
            vectors++;
            if ({cap_addr, cap_wmask, cap_wen, lat, wrong} !==
                {lv[i].addr & ~32'h3, 4'b0000, 1'b0, 32'd3, 1'b0}) begin
                miscompares++;
                $display("FAIL load_%0d_payload: got addr=%h mask=%b wen=%b lat=%0d wrong_rv=%b",
                         i, cap_addr, cap_wmask, cap_wen, lat, wrong);
            end
        end
    endtask

    task automatic test_arbitration();
        int lat; logic [31:0] rd; bit wrong;
        logic owners [$];
        logic [2:0] order;
        int n_grant;
        int n_resp;
        bit drop_ifu;
        // A fetch first leaves the last-owner bit clear.
        do_txn(1'b0, 32'h0000_0F00, 1'b0, 3'b010, 32'h0, 32'h13, lat, rd, wrong);
        rsp_data  = 32'h0000_0055;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h1000;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h2000;
        lsu_wen   = 1'b0;
        lsu_memop = 3'b010;
        order     = 3'b000;
        n_grant   = 0;
        n_resp    = 0;
        drop_ifu  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) step();
            if (drop_ifu) ifu_valid = 1'b0;
            if (n_grant == 3) lsu_valid = 1'b0;
            #1;
            if (ifu_rvalid || lsu_rvalid) begin
                vectors++;
                if (owners.size() == 0 || ifu_rvalid === lsu_rvalid || lsu_rvalid !== owners[0])
                begin
                    miscompares++;
                    $display("FAIL arb_rvalid_owner: got ifu_rv=%b lsu_rv=%b want owner lsu=%b",
                             ifu_rvalid, lsu_rvalid, owners.size() != 0 ? owners[0] : 1'bx);
                end
                if (owners.size() != 0) void'(owners.pop_front());
                n_resp++;
            end
            if (n_grant < 3 && lsu_valid && lsu_ready) begin
                order[2 - n_grant] = 1'b1;
                owners.push_back(1'b1);
                n_grant++;
            end else if (n_grant < 3 && ifu_valid && ifu_ready) begin
                order[2 - n_grant] = 1'b0;
                owners.push_back(1'b0);
                n_grant++;
                drop_ifu = 1'b1;
            end
            if (n_grant == 3 && n_resp == 3) break;
        end
        ifu_valid = 1'b0;
        lsu_valid = 1'b0;
        vectors++;
        if ({n_grant, order} !== {32'd3, 3'b101}) begin
            miscompares++;
            $display("FAIL arb_grant_order: got %0d grants order=%b want 3 101 (L,I,L)",
                     n_grant, order);
        end
        vectors++;
        if (n_resp !== 3) begin
            miscompares++; $display("FAIL arb_resp_count: got %0d want 3", n_resp);
        end
        step();
    endtask

    task automatic test_gnt_stall();
        bit got;
        gnt_delay = 5;
        spurious  = 1'b1;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h302;
        lsu_wen   = 1'b1;
        lsu_memop = 3'b001;
        lsu_wdata = 32'h0000_ABCD;
        step();
        lsu_valid = 1'b0;
        lsu_addr  = 32'hFFFF_FFFF;
        lsu_wdata = 32'hFFFF_FFFF;
        lsu_memop = 3'b000;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({mem_req, mem_addr, mem_wdata, mem_wmask, mem_wen} !==
                {1'b1, 32'h300, 32'hABCD_ABCD, 4'b1100, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_%0d_payload: got req=%b addr=%h wdata=%h mask=%b wen=%b",
                         c, mem_req, mem_addr, mem_wdata, mem_wmask, mem_wen);
            end
            vectors++;
            if ({ifu_rvalid, lsu_rvalid} !== 2'b00) begin
                miscompares++;
                $display("FAIL stall_%0d_rvalid: got %b%b want 00", c, ifu_rvalid, lsu_rvalid);
            end
            step();
        end
        spurious = 1'b0;
        got      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (lsu_rvalid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if ({got, lsu_rdata} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL stall_completion: got rvalid_seen=%b rdata=%h want 1 0", got, lsu_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        // Reset while the request is still waiting for a grant.
        gnt_delay = 100;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h400;
        step();
        ifu_valid = 1'b0;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++; $display("FAIL rst_req_before: got %b want 1", mem_req);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_req, ifu_ready, lsu_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_req_async: got req=%b rdy=%b%b want 000", mem_req, ifu_ready,
                     lsu_ready);
        end
        gnt_delay = 0;
        gnt_fired = 1'b0;
        mem_gnt   = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if ({ifu_rvalid, lsu_rvalid, mem_req} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_req_after_%0d: got rv=%b%b req=%b want 000", c, ifu_rvalid,
                         lsu_rvalid, mem_req);
            end
        end
        // Reset in WAIT, then a stray mem_rvalid while idle.
        rsp_hold  = 1'b1;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h500;
        lsu_wen   = 1'b0;
        lsu_memop = 3'b010;
        step();
        lsu_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_req, lsu_ready, lsu_rvalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_wait_async: got req=%b rdy=%b rv=%b want 000", mem_req,
                     lsu_ready, lsu_rvalid);
        end
        rsp_hold = 1'b0;
        step();
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if ({ifu_rvalid, lsu_rvalid, lsu_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL rst_wait_after_%0d: got rv=%b%b rdy=%b want 001", c, ifu_rvalid,
                         lsu_rvalid, lsu_ready);
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] rd; bit wrong;
        mem_auto = 1'b0;
        do_txn(1'b0, 32'h600, 1'b0, 3'b010, 32'h0, 32'h0, lat, rd, wrong);
        vectors++;
        if ({lat, rd} !== {32'd11, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL timeout_resp: got lat=%0d rdata=%h want 11 deadbeef", lat, rd);
        end
        vectors++;
        if ({err, mem_req} !== 2'b10) begin
            miscompares++; $display("FAIL timeout_err: got err=%b req=%b want 1 0", err, mem_req);
        end
        mem_auto = 1'b1;
        do_txn(1'b0, 32'h604, 1'b0, 3'b010, 32'h0, 32'h0000_0013, lat, rd, wrong);
        vectors++;
        if ({err, rd} !== {1'b1, 32'h0000_0013}) begin
            miscompares++;
            $display("FAIL timeout_sticky: got err=%b rdata=%h want 1 00000013", err, rd);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_err_reset: got %b want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_arbitration();
        test_gnt_stall();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL err_tied_low: got %b want 0", err);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
